// File: rtl/fpu_rq_pkg.sv
// rtl/fpu_rq_pkg.sv - shared types and constants for the FPU result queue
// Queue control state, FPU unit indices and exception flag bit positions.
package fpu_rq_pkg;

  typedef enum logic [1:0] {
    RQ_EMPTY  = 2'd0,
    RQ_ACTIVE = 2'd1,
    RQ_FULL   = 2'd2
  } rq_state_e;

  localparam logic [3:0] UNIT_FCLASS = 4'd0;
  localparam logic [3:0] UNIT_FMINMAX = 4'd1;
  localparam logic [3:0] UNIT_FCMP   = 4'd2;
  localparam logic [3:0] UNIT_FSGNJ  = 4'd3;
  localparam logic [3:0] UNIT_F2I    = 4'd4;
  localparam logic [3:0] UNIT_I2F    = 4'd5;
  localparam logic [3:0] UNIT_ADD    = 4'd6;
  localparam logic [3:0] UNIT_SUB    = 4'd7;
  localparam logic [3:0] UNIT_MUL    = 4'd8;
  localparam logic [3:0] UNIT_DIV    = 4'd9;
  localparam logic [3:0] UNIT_SQRT   = 4'd10;

  // Exception flag layout {NV,DZ,OF,UF,NX}
  localparam int EXC_NV = 4;
  localparam int EXC_DZ = 3;
  localparam int EXC_OF = 2;
  localparam int EXC_UF = 1;
  localparam int EXC_NX = 0;

endpackage

// File: rtl/fpu_rq_mem.sv
// rtl/fpu_rq_mem.sv - entry storage for the FPU result queue
// One synchronous write port, one asynchronous read port; contents are not reset.
module fpu_rq_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fpu_result_queue.sv
// rtl/fpu_result_queue.sv - FIFO of completed FPU results with sticky fflags and irq
// Optional FPU_RQ_EXC_TAG_EN: store exceptions and unit index alongside each result.
module fpu_result_queue
  import fpu_rq_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int EXC_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_result,
  input  logic [EXC_W-1:0]         in_exc,
  input  logic [3:0]               in_unit,
  input  logic                     pop,
  input  logic                     fflags_clr,
  output logic [DATA_W-1:0]        rd_result,
  output logic [EXC_W-1:0]         rd_exc,
  output logic [3:0]               rd_unit,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [EXC_W-1:0]         fflags,
  output logic                     overflow,
  output logic                     irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef FPU_RQ_EXC_TAG_EN
  localparam int ENT_W = DATA_W + EXC_W + 4;
`else
  localparam int ENT_W = DATA_W;
`endif

  rq_state_e     state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic [ENT_W-1:0] wr_entry;
  logic [ENT_W-1:0] rd_entry;
  logic push;
  logic pop_ok;
  logic drop;

  assign empty  = (state == RQ_EMPTY);
  assign full   = (state == RQ_FULL);
  assign push   = in_valid & (~full | pop);
  assign pop_ok = pop & ~empty;
  assign drop   = in_valid & full & ~pop;

  always_comb begin
    count_nxt = count_q;
    if (push && !pop_ok) begin
      count_nxt = count_q + CW'(1);
    end else if (pop_ok && !push) begin
      count_nxt = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RQ_EMPTY;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count_q <= count_nxt;
      case (state)
        RQ_EMPTY: begin
          if (push) begin
            state <= RQ_ACTIVE;
          end
        end
        RQ_ACTIVE: begin
          if (count_nxt == CW'(DEPTH)) begin
            state <= RQ_FULL;
          end else if (count_nxt == '0) begin
            state <= RQ_EMPTY;
          end
        end
        RQ_FULL: begin
          if (pop_ok && !push) begin
            state <= RQ_ACTIVE;
          end
        end
        default: state <= RQ_EMPTY;
      endcase
    end
  end

  // A clear in the same cycle as a completion keeps only that completion's flags
  always_ff @(posedge clk) begin
    if (rst) begin
      fflags   <= '0;
      overflow <= 1'b0;
    end else if (fflags_clr) begin
      fflags   <= in_valid ? in_exc : '0;
      overflow <= drop;
    end else begin
      if (in_valid) begin
        fflags <= fflags | in_exc;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef FPU_RQ_EXC_TAG_EN
  assign wr_entry = {in_result, in_exc, in_unit};
`else
  assign wr_entry = in_result;
`endif

  fpu_rq_mem #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

`ifdef FPU_RQ_EXC_TAG_EN
  assign rd_result = empty ? '0 : rd_entry[ENT_W-1 -: DATA_W];
  assign rd_exc    = empty ? '0 : rd_entry[EXC_W+3 -: EXC_W];
  assign rd_unit   = empty ? '0 : rd_entry[3:0];
`else
  logic unused_unit;
  assign unused_unit = ^in_unit;
  assign rd_result   = empty ? '0 : rd_entry;
  assign rd_exc      = '0;
  assign rd_unit     = '0;
`endif

  assign count = count_q;
  assign irq   = ~empty | overflow;

endmodule

// File: tb/tb_fpu_result_queue.sv
// tb/tb_fpu_result_queue.sv - self-checking bench for fpu_result_queue
// Queue-based reference model checked every cycle, plus directed literal checks.
module tb_fpu_result_queue;

  localparam int DEPTH = 8;
`ifdef FPU_RQ_EXC_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_result;
  logic [4:0]  in_exc;
  logic [3:0]  in_unit;
  logic        pop;
  logic        fflags_clr;
  logic [31:0] rd_result;
  logic [4:0]  rd_exc;
  logic [3:0]  rd_unit;
  logic        empty;
  logic        full;
  logic [3:0]  count;
  logic [4:0]  fflags;
  logic        overflow;
  logic        irq;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [31:0] r;
    logic [4:0]  e;
    logic [3:0]  u;
  } ent_t;

  ent_t        mq[$];
  logic [4:0]  m_fflags = '0;
  logic        m_ovf = 1'b0;

  always #5 clk = ~clk;

  fpu_result_queue #(.DEPTH(DEPTH), .DATA_W(32), .EXC_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_result(in_result),
    .in_exc(in_exc), .in_unit(in_unit), .pop(pop), .fflags_clr(fflags_clr),
    .rd_result(rd_result), .rd_exc(rd_exc), .rd_unit(rd_unit), .empty(empty),
    .full(full), .count(count), .fflags(fflags), .overflow(overflow), .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: update on each rising edge from the inputs held since the falling edge
  always @(posedge clk) begin
    bit was_full, drop_m, push_m, pop_m;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_fflags = '0;
      m_ovf = 1'b0;
    end else begin
      was_full = (mq.size() == DEPTH);
      pop_m  = pop && (mq.size() > 0);
      push_m = in_valid && (!was_full || pop);
      drop_m = in_valid && was_full && !pop;
      if (pop_m) void'(mq.pop_front());
      if (push_m) begin
        e.r = in_result; e.e = in_exc; e.u = in_unit;
        mq.push_back(e);
      end
      if (fflags_clr) begin
        m_fflags = in_valid ? in_exc : 5'd0;
        m_ovf = drop_m;
      end else begin
        if (in_valid) m_fflags = m_fflags | in_exc;
        if (drop_m) m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_empty", 32'(empty), 32'(mq.size() == 0));
      check("m_full", 32'(full), 32'(mq.size() == DEPTH));
      check("m_count", 32'(count), 32'(mq.size()));
      check("m_fflags", 32'(fflags), 32'(m_fflags));
      check("m_overflow", 32'(overflow), 32'(m_ovf));
      check("m_irq", 32'(irq), 32'((mq.size() != 0) || m_ovf));
      check("m_rd_result", rd_result, (mq.size() != 0) ? mq[0].r : 32'd0);
      check("m_rd_exc", 32'(rd_exc), (TAG_EN && mq.size() != 0) ? 32'(mq[0].e) : 32'd0);
      check("m_rd_unit", 32'(rd_unit), (TAG_EN && mq.size() != 0) ? 32'(mq[0].u) : 32'd0);
    end
  end

  task automatic cyc(input logic v, input logic [31:0] r, input logic [4:0] e,
                     input logic [3:0] u, input logic p, input logic c);
    in_valid = v; in_result = r; in_exc = e; in_unit = u; pop = p; fflags_clr = c;
    @(negedge clk);
    in_valid = 1'b0; in_result = '0; in_exc = '0; in_unit = '0; pop = 1'b0; fflags_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_result = '0; in_exc = '0; in_unit = '0; pop = 1'b0; fflags_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_count", 32'(count), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_rd_result", rd_result, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    check("idle_empty", 32'(empty), 32'd1);

    cyc(1, 32'h3F800000, 5'b00001, 4'd6, 0, 0);
    check("t2_rd_result", rd_result, 32'h3F800000);
    check("t2_rd_exc", 32'(rd_exc), TAG_EN ? 32'd1 : 32'd0);
    check("t2_rd_unit", 32'(rd_unit), TAG_EN ? 32'd6 : 32'd0);
    check("t2_count", 32'(count), 32'd1);
    check("t2_fflags", 32'(fflags), 32'd1);
    check("t2_irq", 32'(irq), 32'd1);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1);
    check("t2_cleared", 32'(fflags), 32'd0);

    for (int i = 1; i <= 9; i++) cyc(1, 32'(i), 5'd0, 4'd0, 0, 0);
    check("t3_full", 32'(full), 32'd1);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_count", 32'(count), 32'd8);
    check("t3_head", rd_result, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      check("t3_pop_val", rd_result, 32'(i));
      cyc(0, 0, 0, 0, 1, 0);
    end
    check("t3_empty", 32'(empty), 32'd1);
    check("t3_irq_ovf", 32'(irq), 32'd1);
    cyc(0, 0, 0, 0, 0, 1);
    check("t3_ovf_clr", 32'(overflow), 32'd0);

    for (int i = 1; i <= 8; i++) cyc(1, 32'(i + 16), 5'd0, 4'd0, 0, 0);
    cyc(1, 32'hA, 5'd0, 4'd0, 1, 0);
    check("t4_count", 32'(count), 32'd8);
    check("t4_overflow", 32'(overflow), 32'd0);
    check("t4_head", rd_result, 32'd18);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("t4_last", rd_result, 32'hA);
      cyc(0, 0, 0, 0, 1, 0);
    end
    check("t4_empty", 32'(empty), 32'd1);

    cyc(1, 32'h5, 5'b10000, 4'd9, 0, 0);
    check("t5_fflags_set", 32'(fflags), 32'b10000);
    cyc(1, 32'h6, 5'b00100, 4'd8, 0, 1);
    check("t5_fflags_clr", 32'(fflags), 32'b00100);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    check("t5_underflow", 32'(count), 32'd0);
    check("t5_empty", 32'(empty), 32'd1);

    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 32'h7, 5'b11111, 4'd10, 0, 0);
    check("t6_rd_exc", 32'(rd_exc), TAG_EN ? 32'd31 : 32'd0);
    check("t6_rd_unit", 32'(rd_unit), TAG_EN ? 32'd10 : 32'd0);
    check("t6_fflags", 32'(fflags), 32'b11111);

    cyc(1, 32'h8, 5'b00010, 4'd1, 0, 0);
    cyc(1, 32'h9, 5'b00000, 4'd2, 1, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_count", 32'(count), 32'd0);
    check("rst_mid_empty", 32'(empty), 32'd1);
    check("rst_mid_fflags", 32'(fflags), 32'd0);
    check("rst_mid_rd", rd_result, 32'd0);
    cyc(1, 32'hB, 5'd0, 4'd3, 0, 0);
    check("after_rst_head", rd_result, 32'hB);
    cyc(0, 0, 0, 0, 0, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
